// File: rtl/sram_access_responder_pkg.sv
// Shared definitions for the SRAM access path: FSM state encoding and widths
// used by the responder and its wait-state counter.
package mem_if_pkg;

   localparam int SRAM_ADDR_W = 26;
   localparam int WAIT_CNT_W  = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      ACCESS = 3'd2,
      HOLD   = 3'd3,
      RESP   = 3'd4
   } sram_state_t;

endpackage

// File: rtl/sram_access_responder_wait_counter.sv
// Load/decrement down-counter that times how long the SRAM strobes stay
// active; saturates at zero and flags it.
module access_wait_counter
   import mem_if_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_load,
   input  logic                  i_dec,
   input  logic [WAIT_CNT_W-1:0] i_loadValue,
   output logic                  o_zero
);

   logic [WAIT_CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_loadValue;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/sram_access_responder.sv
// Memory-side responder: takes one read/write request at a time, drives an
// async SRAM with programmable wait states and returns read data.
module sram_access_responder
   import mem_if_pkg::*;
#(
   parameter int ADDR_W      = SRAM_ADDR_W,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata,
   output logic              sram_ce,
   output logic              sram_oe,
   output logic              sram_we,
   output logic              busy
);

   if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 15)) begin : gBadWait
      $error("sram_access_responder: WAIT_CYCLES must be within 1..15");
   end

   sram_state_t       r_state;
   sram_state_t       w_nextState;
   logic              r_wr;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              w_accept;
   logic              w_waitDone;

   assign req_ready = (r_state == IDLE);
   assign w_accept  = req_valid && req_ready;

   // The counter is loaded during SETUP so ACCESS lasts exactly WAIT_CYCLES cycles.
   access_wait_counter uWaitCounter (
      .clk         (clk),
      .rst         (rst),
      .i_load      (r_state == SETUP),
      .i_dec       (r_state == ACCESS),
      .i_loadValue (WAIT_CNT_W'(WAIT_CYCLES - 1)),
      .o_zero      (w_waitDone)
   );

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_nextState = SETUP;
         SETUP:   w_nextState = ACCESS;
         ACCESS:  if (w_waitDone) w_nextState = r_wr ? HOLD : RESP;
         HOLD:    w_nextState = IDLE;
         RESP:    if (rsp_ready) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_wr    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         r_state <= w_nextState;
         if (w_accept) begin
            r_wr    <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
         end
         // Read data is sampled on the last ACCESS edge while OE is still asserted.
         if ((r_state == ACCESS) && w_waitDone && !r_wr) begin
            r_rdata <= sram_rdata;
         end
      end
   end

   assign sram_ce    = (r_state == SETUP) || (r_state == ACCESS) || (r_state == HOLD);
   assign sram_oe    = ((r_state == SETUP) || (r_state == ACCESS)) && !r_wr;
   assign sram_we    = (r_state == ACCESS) && r_wr;
   assign sram_addr  = r_addr;
   assign sram_wdata = r_wdata;
   assign rsp_rdata  = r_rdata;
   assign rsp_valid  = (r_state == RESP);
   assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_sram_access_responder.sv
// Bench for sram_access_responder: three builds (WAIT_CYCLES 1, 2, 15) share one
// SRAM model; results are checked against a request-level memory model.
module tb_sram_access_responder;

   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        reqValid  [NI];
   logic        reqReady  [NI];
   logic        reqWrite  [NI];
   logic [25:0] reqAddr   [NI];
   logic [31:0] reqWdata  [NI];
   logic        rspValid  [NI];
   logic        rspReady  [NI];
   logic [31:0] rspRdata  [NI];
   logic [25:0] sramAddr  [NI];
   logic [31:0] sramWdata [NI];
   logic [31:0] sramRdata [NI];
   logic        sramCe    [NI];
   logic        sramOe    [NI];
   logic        sramWe    [NI];
   logic        busy      [NI];

   for (genvar g = 0; g < NI; g++) begin : gDut
      sram_access_responder #(
         .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 2 : 15))
      ) uDut (
         .clk        (clk),
         .rst        (rst),
         .req_valid  (reqValid[g]),
         .req_ready  (reqReady[g]),
         .req_write  (reqWrite[g]),
         .req_addr   (reqAddr[g]),
         .req_wdata  (reqWdata[g]),
         .rsp_valid  (rspValid[g]),
         .rsp_ready  (rspReady[g]),
         .rsp_rdata  (rspRdata[g]),
         .sram_addr  (sramAddr[g]),
         .sram_wdata (sramWdata[g]),
         .sram_rdata (sramRdata[g]),
         .sram_ce    (sramCe[g]),
         .sram_oe    (sramOe[g]),
         .sram_we    (sramWe[g]),
         .busy       (busy[g])
      );
   end

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;
   int busyRises  = 0;
   bit monOn      = 1'b0;
   logic prevBusy1 = 1'b0;

   logic [31:0] sramMem [logic [25:0]];
   logic [31:0] refMem  [logic [25:0]];

   typedef struct {
      int          idx;
      logic        wr;
      logic [25:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } vec_t;

   function automatic int waitOf(input int i);
      case (i)
         0:       return 1;
         1:       return 2;
         default: return 15;
      endcase
   endfunction

   // Power-up contents of the external SRAM.
   function automatic logic [31:0] initPat(input logic [25:0] a);
      if (a == 26'h3FFFFFF) return 32'hA5A50F0F;
      return {6'd0, a} ^ 32'h5A5A5A5A;
   endfunction

   function automatic logic [31:0] sramRead(input logic [25:0] a);
      return sramMem.exists(a) ? sramMem[a] : initPat(a);
   endfunction

   function automatic logic [31:0] refExpect(input logic [25:0] a);
      return refMem.exists(a) ? refMem[a] : initPat(a);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // SRAM model: writes land on the clock edge, read data is only driven while OE is up.
   always @(posedge clk) begin
      for (int g = 0; g < NI; g++) begin
         if (sramCe[g] && sramWe[g]) sramMem[sramAddr[g]] = sramWdata[g];
      end
   end

   always @(negedge clk) begin
      for (int g = 0; g < NI; g++) begin
         sramRdata[g] = (sramCe[g] && sramOe[g]) ? sramRead(sramAddr[g]) : 32'hBAD0BAD0;
      end
   end

   always @(negedge clk) begin
      if (monOn) begin
         for (int g = 0; g < NI; g++) begin
            checkOutput($sformatf("strobe_we_oe_%0d", g), 64'(sramWe[g] & sramOe[g]), 64'd0);
            checkOutput($sformatf("strobe_idle_resp_%0d", g),
                        64'((!busy[g] || rspValid[g]) && (sramCe[g] || sramOe[g] || sramWe[g])), 64'd0);
         end
         if (busy[1] && !prevBusy1) busyRises++;
         prevBusy1 = busy[1];
      end
   end

   // Issues one request from an idle negedge and checks latency and data.
   task automatic applyStimulus(input int i, input logic wr, input logic [25:0] addr,
                                input logic [31:0] wdata, input logic [31:0] expRdata,
                                input int rspDelay, input string name);
      int w, k, vK, rK, d;
      w = waitOf(i);
      checkOutput({name, "_idle"}, 64'(reqReady[i]), 64'd1);
      reqValid[i] = 1'b1;
      reqWrite[i] = wr;
      reqAddr[i]  = addr;
      reqWdata[i] = wdata;
      rspReady[i] = (rspDelay == 0);
      if (wr) refMem[addr] = wdata;
      @(negedge clk);
      reqValid[i] = 1'b0;
      reqAddr[i]  = 26'($urandom());
      reqWdata[i] = $urandom();
      checkOutput({name, "_addr"}, 64'(sramAddr[i]), 64'(addr));
      if (wr) checkOutput({name, "_wdata"}, 64'(sramWdata[i]), 64'(wdata));
      k = 1; vK = -1; rK = -1; d = 0;
      while (k < 80) begin
         if (reqReady[i]) begin
            rK = k;
            break;
         end
         if (rspValid[i]) begin
            if (vK < 0) vK = k;
            checkOutput({name, "_rdata"}, 64'(rspRdata[i]), 64'(expRdata));
            if (!rspReady[i]) begin
               if (d == rspDelay) rspReady[i] = 1'b1;
               else d++;
            end
         end
         @(negedge clk);
         k++;
      end
      rspReady[i] = 1'b1;
      if (wr) begin
         checkOutput({name, "_wlat"}, 64'(rK), 64'(3 + w));
         checkOutput({name, "_novalid"}, 64'(vK), 64'(-1));
      end else begin
         checkOutput({name, "_vlat"}, 64'(vK), 64'(2 + w));
         checkOutput({name, "_rlat"}, 64'(rK), 64'(3 + w + rspDelay));
         checkOutput({name, "_rhold"}, 64'(rspRdata[i]), 64'(expRdata));
         checkOutput({name, "_vlow"}, 64'(rspValid[i]), 64'd0);
      end
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   vec_t        vecs [8];
   vec_t        bq   [4];
   logic [25:0] pool [8];
   logic [31:0] got  [$];

   initial begin
      int          head, cyc, rises0, ii, dly;
      logic        wasReady, wr;
      logic [25:0] a;
      logic [31:0] wd;
      logic [4:0]  e;

      for (int i = 0; i < NI; i++) begin
         reqValid[i] = 1'b0;
         reqWrite[i] = 1'b0;
         reqAddr[i]  = '0;
         reqWdata[i] = '0;
         rspReady[i] = 1'b1;
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         checkOutput($sformatf("reset_ctrl_%0d", i),
                     64'({reqReady[i], busy[i], rspValid[i], sramCe[i], sramOe[i], sramWe[i]}), 64'b100000);
         checkOutput($sformatf("reset_addr_%0d", i), 64'(sramAddr[i]), 64'd0);
         checkOutput($sformatf("reset_wdata_%0d", i), 64'(sramWdata[i]), 64'd0);
         checkOutput($sformatf("reset_rdata_%0d", i), 64'(rspRdata[i]), 64'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      monOn = 1'b1;

      // Write with WAIT_CYCLES=2, checked cycle by cycle.
      reqValid[1] = 1'b1; reqWrite[1] = 1'b1; reqAddr[1] = 26'h0001234; reqWdata[1] = 32'hDEADBEEF;
      refMem[26'h0001234] = 32'hDEADBEEF;
      @(negedge clk);
      reqValid[1] = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         e = {(k <= 4), 1'b0, (k == 2 || k == 3), (k == 5), (k <= 4)};
         checkOutput($sformatf("wr_seq_k%0d", k),
                     64'({sramCe[1], sramOe[1], sramWe[1], reqReady[1], busy[1]}), 64'(e));
         if (k < 5) @(negedge clk);
      end

      applyStimulus(1, 1'b0, 26'h3FFFFFF, 32'h0, 32'hA5A50F0F, 0, "rd_top");
      applyStimulus(1, 1'b0, 26'h0001234, 32'h0, 32'hDEADBEEF, 5, "rd_bp");

      vecs[0] = '{1, 1'b1, 26'h0000010, 32'h11223344, 32'h0};
      vecs[1] = '{1, 1'b0, 26'h0000010, 32'h0,        32'h11223344};
      vecs[2] = '{0, 1'b1, 26'h2000000, 32'h12345678, 32'h0};
      vecs[3] = '{0, 1'b0, 26'h2000000, 32'h0,        32'h12345678};
      vecs[4] = '{2, 1'b1, 26'h0000000, 32'hCAFEF00D, 32'h0};
      vecs[5] = '{2, 1'b0, 26'h0000000, 32'h0,        32'hCAFEF00D};
      vecs[6] = '{2, 1'b0, 26'h3FFFFFF, 32'h0,        32'hA5A50F0F};
      vecs[7] = '{0, 1'b0, 26'h0000777, 32'h0,        32'h5A5A5D2D};
      for (int j = 0; j < 8; j++) begin
         applyStimulus(vecs[j].idx, vecs[j].wr, vecs[j].addr, vecs[j].wdata, vecs[j].rdata, 0,
                       $sformatf("vec%0d", j));
      end

      // Reset in the middle of a read, with a request presented during reset.
      reqValid[1] = 1'b1; reqWrite[1] = 1'b0; reqAddr[1] = 26'h0000ABC;
      @(negedge clk);
      reqValid[1] = 1'b0;
      @(negedge clk);
      checkOutput("rst_pre_access", 64'({sramCe[1], sramOe[1], busy[1]}), 64'b111);
      rst = 1'b1;
      reqValid[1] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput($sformatf("rst_state_%0d", k),
                     64'({sramCe[1], sramOe[1], sramWe[1], rspValid[1], reqReady[1], busy[1]}), 64'b000010);
      end
      rst = 1'b0;
      reqValid[1] = 1'b0;
      @(negedge clk);
      checkOutput("rst_noaccept", 64'(busy[1]), 64'd0);
      repeat (6) @(negedge clk);
      checkOutput("rst_norsp", 64'({rspValid[1], busy[1]}), 64'd0);
      checkOutput("rst_rdata_clr", 64'(rspRdata[1]), 64'd0);

      // Back-to-back requests with req_valid held high.
      bq[0] = '{1, 1'b1, 26'h1555555, 32'h0BADF00D, 32'h0};
      bq[1] = '{1, 1'b0, 26'h1555555, 32'h0,        32'h0BADF00D};
      bq[2] = '{1, 1'b1, 26'h2AAAAAA, 32'h600DCAFE, 32'h0};
      bq[3] = '{1, 1'b0, 26'h2AAAAAA, 32'h0,        32'h600DCAFE};
      rises0 = busyRises;
      got.delete();
      head = 0; cyc = 0;
      reqValid[1] = 1'b1; reqWrite[1] = bq[0].wr; reqAddr[1] = bq[0].addr; reqWdata[1] = bq[0].wdata;
      while (head < 4 && cyc < 200) begin
         wasReady = reqReady[1];
         @(negedge clk);
         cyc++;
         if (rspValid[1]) got.push_back(rspRdata[1]);
         if (wasReady) begin
            checkOutput($sformatf("b2b_addr%0d", head), 64'(sramAddr[1]), 64'(bq[head].addr));
            if (bq[head].wr) refMem[bq[head].addr] = bq[head].wdata;
            head++;
            if (head < 4) begin
               reqWrite[1] = bq[head].wr; reqAddr[1] = bq[head].addr; reqWdata[1] = bq[head].wdata;
            end else begin
               reqValid[1] = 1'b0;
            end
         end
      end
      reqValid[1] = 1'b0;
      while (busy[1] && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (rspValid[1]) got.push_back(rspRdata[1]);
      end
      checkOutput("b2b_accepts", 64'(busyRises - rises0), 64'd4);
      checkOutput("b2b_rsp_count", 64'(got.size()), 64'd2);
      if (got.size() >= 2) begin
         checkOutput("b2b_rsp0", 64'(got[0]), 64'(bq[1].rdata));
         checkOutput("b2b_rsp1", 64'(got[1]), 64'(bq[3].rdata));
      end

      // Randomized traffic against the request-level memory model.
      pool[0] = 26'h0000000;
      pool[1] = 26'h3FFFFFF;
      for (int j = 2; j < 8; j++) pool[j] = 26'($urandom());
      for (int n = 0; n < 40; n++) begin
         ii  = int'($urandom_range(0, 2));
         wr  = 1'($urandom_range(0, 1));
         a   = pool[$urandom_range(0, 7)];
         wd  = $urandom();
         dly = int'($urandom_range(0, 3));
         applyStimulus(ii, wr, a, wd, wr ? 32'h0 : refExpect(a), dly, $sformatf("rnd%0d", n));
      end

      monOn = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
